xgxs_tx_colgen: RTL and testbench

Four-lane XGXS transmit column generator. Accepts one 32-bit XGMII transmit column per clock, translates XGMII control characters into 8b10b code-group requests, and replaces all-idle columns with the randomised ||A||/||K||/||R|| idle pattern. It sits directly upstream of the four per-lane 8b10b encoders. Per lane, it drives the encoder's 8-bit data input and its konstant flag.

---
 rtl/xgxs_tx_colgen.sv | 99 +++++++++
 tb/tb_xgxs_tx_colgen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/xgxs_tx_colgen.sv
// XGXS transmit column generator: maps XGMII control characters to 8b10b
// code-group requests and replaces all-idle columns with the ||A||/||K||/||R|| idle pattern.
module xgxs_tx_colgen (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] xgmii_txd,
    input  logic [3:0]  xgmii_txc,
    output logic [31:0] tx_data,
    output logic [3:0]  tx_konst,
    output logic        tx_col_is_idle
);

    localparam logic [7:0] SYM_IDLE = 8'h07;
    localparam logic [7:0] SYM_S    = 8'hFB;
    localparam logic [7:0] SYM_T    = 8'hFD;
    localparam logic [7:0] SYM_E    = 8'hFE;
    localparam logic [7:0] SYM_Q    = 8'h9C;
    localparam logic [7:0] SYM_K    = 8'hBC;
    localparam logic [7:0] SYM_A    = 8'h7C;
    localparam logic [7:0] SYM_R    = 8'h1C;

    // The state register doubles as the previous-column classification.
    typedef enum logic {
        ST_DATA = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  a_cnt_q, a_cnt_d;
    logic [6:0]  prbs_q, prbs_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  konst_q, konst_d;
    logic        col_is_idle;
    logic [7:0]  idle_char;

    // Returns {konst, byte} for one lane of a non-idle column.
    function automatic logic [8:0] map_lane(input logic [7:0] b, input logic c, input logic is_lane0);
        if (!c) begin
            return {1'b0, b};
        end
        case (b)
            SYM_S:               return is_lane0 ? {1'b1, SYM_S} : {1'b1, SYM_E};
            SYM_T, SYM_E, SYM_Q: return {1'b1, b};
            SYM_IDLE:            return {1'b1, SYM_K};
            default:             return {1'b1, SYM_E};
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        col_is_idle = (xgmii_txc == 4'hF) && (xgmii_txd == {4{SYM_IDLE}});
        idle_char   = SYM_K;
        a_cnt_d     = (a_cnt_q == 5'd0) ? 5'd0 : a_cnt_q - 5'd1;
        prbs_d      = prbs_q;
        data_d      = '0;
        konst_d     = '0;
        state_d     = col_is_idle ? ST_IDLE : ST_DATA;

        if (col_is_idle) begin
            if (a_cnt_q == 5'd0) begin
                idle_char = SYM_A;
                a_cnt_d   = {1'b1, prbs_q[3:0]};
            end else if (state_q == ST_DATA || prbs_q[0]) begin
                idle_char = SYM_K;
            end else begin
                idle_char = SYM_R;
            end
            prbs_d  = {prbs_q[5:0], prbs_q[6] ^ prbs_q[5]};
            data_d  = {4{idle_char}};
            konst_d = 4'hF;
        end else begin
            for (int n = 0; n < 4; n++) begin
                {konst_d[n], data_d[8*n +: 8]} = map_lane(xgmii_txd[8*n +: 8], xgmii_txc[n], n == 0);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_DATA;
            a_cnt_q <= 5'd0;
            prbs_q  <= 7'h7F;
            data_q  <= {4{SYM_K}};
            konst_q <= 4'hF;
        end else begin
            state_q <= state_d;
            a_cnt_q <= a_cnt_d;
            prbs_q  <= prbs_d;
            data_q  <= data_d;
            konst_q <= konst_d;
        end
    end

    assign tx_data        = data_q;
    assign tx_konst       = konst_q;
    assign tx_col_is_idle = (state_q == ST_IDLE);

endmodule

// File: tb/tb_xgxs_tx_colgen.sv
// Self-checking bench for xgxs_tx_colgen: vector table, directed idle/reset
// sequences and randomized columns against a behavioural model.
module tb_xgxs_tx_colgen;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] xgmii_txd;
    logic [3:0]  xgmii_txc;
    logic [31:0] tx_data;
    logic [3:0]  tx_konst;
    logic        tx_col_is_idle;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    int         m_acnt;
    logic [6:0] m_prbs;
    bit         m_prev_idle;
    logic [31:0] ex_data;
    logic [3:0]  ex_konst;
    bit          ex_idle;

    typedef struct {
        logic [31:0] txd;
        logic [3:0]  txc;
        logic [31:0] exp_data;
        logic [3:0]  exp_konst;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    xgxs_tx_colgen dut (
        .clk            (clk),
        .rst            (rst),
        .xgmii_txd      (xgmii_txd),
        .xgmii_txc      (xgmii_txc),
        .tx_data        (tx_data),
        .tx_konst       (tx_konst),
        .tx_col_is_idle (tx_col_is_idle)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_acnt      = 0;
        m_prbs      = 7'h7F;
        m_prev_idle = 0;
        ex_data     = 32'hBCBCBCBC;
        ex_konst    = 4'hF;
        ex_idle     = 0;
    endfunction

    function automatic void model_col(input logic [31:0] txd, input logic [3:0] txc);
        bit idle = (txc == 4'hF) && (txd == 32'h07070707);
        logic [7:0] ch;
        logic [7:0] b;
        if (idle) begin
            if (m_acnt == 0)        ch = 8'h7C;
            else if (!m_prev_idle)  ch = 8'hBC;
            else if (m_prbs[0])     ch = 8'hBC;
            else                    ch = 8'h1C;
            m_acnt   = (m_acnt == 0) ? 16 + int'(m_prbs[3:0]) : m_acnt - 1;
            m_prbs   = {m_prbs[5:0], m_prbs[6] ^ m_prbs[5]};
            ex_data  = {ch, ch, ch, ch};
            ex_konst = 4'hF;
        end else begin
            for (int n = 0; n < 4; n++) begin
                b = txd[8*n +: 8];
                ex_konst[n] = txc[n];
                if (!txc[n])                                 ex_data[8*n +: 8] = b;
                else if (b == 8'hFB)                         ex_data[8*n +: 8] = (n == 0) ? 8'hFB : 8'hFE;
                else if (b == 8'hFD || b == 8'hFE || b == 8'h9C) ex_data[8*n +: 8] = b;
                else if (b == 8'h07)                         ex_data[8*n +: 8] = 8'hBC;
                else                                         ex_data[8*n +: 8] = 8'hFE;
            end
            m_acnt = (m_acnt > 0) ? m_acnt - 1 : 0;
        end
        m_prev_idle = idle;
        ex_idle     = idle;
    endfunction

    // Apply one column (or a reset cycle), advance the model, sample #1 after the edge.
    task automatic step(input bit r, input logic [31:0] txd, input logic [3:0] txc);
        rst       = r;
        xgmii_txd = txd;
        xgmii_txc = txc;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else   model_col(txd, txc);
    endtask

    task automatic check_model(input string name);
        check(name, {27'd0, tx_col_is_idle, tx_konst, tx_data}, {27'd0, ex_idle, ex_konst, ex_data});
    endtask

    initial begin
        int last_a;
        int col;
        logic [31:0] rtxd;
        logic [3:0]  rtxc;
        logic [7:0]  pool[8];

        vecs[0] = '{32'h44332211, 4'h0, 32'h44332211, 4'h0};
        vecs[1] = '{32'h0707FD11, 4'hE, 32'hBCBCFD11, 4'hE};
        vecs[2] = '{32'h00FB0000, 4'h4, 32'h00FE0000, 4'h4};
        vecs[3] = '{32'h00005500, 4'h2, 32'h0000FE00, 4'h2};
        vecs[4] = '{32'h555555FB, 4'h1, 32'h555555FB, 4'h1};
        vecs[5] = '{32'hFBFBFBFB, 4'hF, 32'hFEFEFEFB, 4'hF};
        vecs[6] = '{32'h9CFEFD07, 4'hF, 32'h9CFEFDBC, 4'hF};
        vecs[7] = '{32'h07070707, 4'h7, 32'h07BCBCBC, 4'h7};
        vecs[8] = '{32'h07070707, 4'h0, 32'h07070707, 4'h0};

        pool[0] = 8'h07; pool[1] = 8'hFB; pool[2] = 8'hFD; pool[3] = 8'hFE;
        pool[4] = 8'h9C; pool[5] = 8'h55; pool[6] = 8'h00; pool[7] = 8'hBC;

        // Reset state
        step(1, 32'h0, 4'h0);
        check("reset_out", {27'd0, tx_col_is_idle, tx_konst, tx_data}, {27'd0, 1'b0, 4'hF, 32'hBCBCBCBC});
        step(0, 32'h07070707, 4'hF);
        check("first_idle_A", {27'd0, tx_col_is_idle, tx_konst, tx_data}, {27'd0, 1'b1, 4'hF, 32'h7C7C7C7C});
        step(0, 32'h07070707, 4'hF);
        check("second_idle_R", {32'd0, tx_data}, {32'd0, 32'h1C1C1C1C});
        // Next ||A|| exactly 32 columns after the first
        last_a = -1;
        for (int i = 3; i <= 33; i++) begin
            step(0, 32'h07070707, 4'hF);
            check_model("idle_run_model");
            if (tx_data == 32'h7C7C7C7C && last_a < 0) last_a = i;
        end
        check("second_A_column", 64'(last_a), 64'd33);

        // Data column after idles
        step(0, 32'h44332211, 4'h0);
        check("data_after_idle", {27'd0, tx_col_is_idle, tx_konst, tx_data}, {27'd0, 1'b0, 4'h0, 32'h44332211});

        // Table of non-idle vectors
        foreach (vecs[i]) begin
            step(0, vecs[i].txd, vecs[i].txc);
            check($sformatf("vec%0d", i), {27'd0, tx_col_is_idle, tx_konst, tx_data},
                  {27'd0, 1'b0, vecs[i].exp_konst, vecs[i].exp_data});
        end

        // /T/ followed by idle: never ||R||
        for (int k = 0; k < 4; k++) begin
            step(0, 32'h0707FD11, 4'hE);
            step(0, 32'h07070707, 4'hF);
            check("idle_after_T_not_R", 64'(tx_data == 32'hBCBCBCBC || tx_data == 32'h7C7C7C7C), 64'd1);
            check_model("idle_after_T_model");
            for (int j = 0; j < 3 + k; j++) step(0, 32'h07070707, 4'hF);
        end

        // Long idle run: A spacing 17..32, R/K pattern vs model
        last_a = -1;
        for (int i = 0; i < 1000; i++) begin
            step(0, 32'h07070707, 4'hF);
            check_model("long_idle_model");
            if (tx_data == 32'h7C7C7C7C) begin
                if (last_a >= 0)
                    check("A_spacing", 64'((i - last_a) >= 17 && (i - last_a) <= 32), 64'd1);
                last_a = i;
            end
        end

        // Randomized mixed columns against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                rtxd = 32'h07070707;
                rtxc = 4'hF;
            end else begin
                rtxc = 4'($urandom_range(0, 15));
                for (int n = 0; n < 4; n++)
                    rtxd[8*n +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
            end
            step(0, rtxd, rtxc);
            check_model("random_model");
        end

        // Reset pulsed mid-packet
        step(0, 32'hDDCCBBFB, 4'h1);
        step(0, 32'h44332211, 4'h0);
        step(1, 32'h88776655, 4'h0);
        check("midpkt_reset", {27'd0, tx_col_is_idle, tx_konst, tx_data}, {27'd0, 1'b0, 4'hF, 32'hBCBCBCBC});
        step(0, 32'h07070707, 4'hF);
        check("post_reset_A", {27'd0, tx_col_is_idle, tx_konst, tx_data}, {27'd0, 1'b1, 4'hF, 32'h7C7C7C7C});
        step(0, 32'h07070707, 4'hF);
        check_model("post_reset_model");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
